// File: rtl/axi_rd_arbiter.sv
// Two-port AXI4 read-channel arbiter: round-robin AR grant, one burst in flight,
// R beats steered back to the granted requester until RLAST.
module axi_rd_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              inport0_arvalid_i,
   input  logic [ADDR_W-1:0] inport0_araddr_i,
   input  logic [ID_W-1:0]   inport0_arid_i,
   input  logic [7:0]        inport0_arlen_i,
   input  logic [1:0]        inport0_arburst_i,
   output logic              inport0_arready_o,
   output logic              inport0_rvalid_o,
   output logic [DATA_W-1:0] inport0_rdata_o,
   output logic [1:0]        inport0_rresp_o,
   output logic [ID_W-1:0]   inport0_rid_o,
   output logic              inport0_rlast_o,
   input  logic              inport0_rready_i,

   input  logic              inport1_arvalid_i,
   input  logic [ADDR_W-1:0] inport1_araddr_i,
   input  logic [ID_W-1:0]   inport1_arid_i,
   input  logic [7:0]        inport1_arlen_i,
   input  logic [1:0]        inport1_arburst_i,
   output logic              inport1_arready_o,
   output logic              inport1_rvalid_o,
   output logic [DATA_W-1:0] inport1_rdata_o,
   output logic [1:0]        inport1_rresp_o,
   output logic [ID_W-1:0]   inport1_rid_o,
   output logic              inport1_rlast_o,
   input  logic              inport1_rready_i,

   output logic              outport_arvalid_o,
   output logic [ADDR_W-1:0] outport_araddr_o,
   output logic [ID_W-1:0]   outport_arid_o,
   output logic [7:0]        outport_arlen_o,
   output logic [1:0]        outport_arburst_o,
   input  logic              outport_arready_i,
   input  logic              outport_rvalid_i,
   input  logic [DATA_W-1:0] outport_rdata_i,
   input  logic [1:0]        outport_rresp_i,
   input  logic [ID_W-1:0]   outport_rid_i,
   input  logic              outport_rlast_i,
   output logic              outport_rready_o
);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e            state_q, state_d;
   logic              grant_q, last_grant_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ID_W-1:0]   id_q;
   logic [7:0]        len_q;
   logic [1:0]        burst_q;

   logic win, accept, grant_rready, r_last_xfer;

   // On a tie the port that did not win last time is chosen.
   always_comb begin
      win = 1'b0;
      if (inport0_arvalid_i && inport1_arvalid_i) begin
         win = ~last_grant_q;
      end else if (inport1_arvalid_i) begin
         win = 1'b1;
      end
   end

   // Gating with rst_i keeps arready low while reset is held.
   assign accept       = (state_q == StIdle) && (inport0_arvalid_i || inport1_arvalid_i) &&
                         !rst_i;
   assign grant_rready = grant_q ? inport1_rready_i : inport0_rready_i;
   assign r_last_xfer  = outport_rvalid_i && grant_rready && outport_rlast_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept)            state_d = StAddr;
         StAddr:  if (outport_arready_i) state_d = StData;
         StData:  if (r_last_xfer)       state_d = StIdle;
         default:                        state_d = StIdle;
      endcase
   end

   always_comb begin
      inport0_arready_o = 1'b0;
      inport1_arready_o = 1'b0;
      inport0_rvalid_o  = 1'b0;
      inport1_rvalid_o  = 1'b0;
      outport_arvalid_o = 1'b0;
      outport_rready_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            inport0_arready_o = accept && !win;
            inport1_arready_o = accept && win;
         end
         StAddr: begin
            outport_arvalid_o = 1'b1;
         end
         StData: begin
            inport0_rvalid_o = !grant_q && outport_rvalid_i;
            inport1_rvalid_o = grant_q && outport_rvalid_i;
            outport_rready_o = grant_rready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         id_q         <= '0;
         len_q        <= '0;
         burst_q      <= '0;
      end else if (accept) begin
         grant_q      <= win;
         last_grant_q <= win;
         addr_q       <= win ? inport1_araddr_i  : inport0_araddr_i;
         id_q         <= win ? inport1_arid_i    : inport0_arid_i;
         len_q        <= win ? inport1_arlen_i   : inport0_arlen_i;
         burst_q      <= win ? inport1_arburst_i : inport0_arburst_i;
      end
   end

   assign outport_araddr_o  = addr_q;
   assign outport_arid_o    = id_q;
   assign outport_arlen_o   = len_q;
   assign outport_arburst_o = burst_q;

   assign inport0_rdata_o = outport_rdata_i;
   assign inport0_rresp_o = outport_rresp_i;
   assign inport0_rid_o   = outport_rid_i;
   assign inport0_rlast_o = outport_rlast_i;
   assign inport1_rdata_o = outport_rdata_i;
   assign inport1_rresp_o = outport_rresp_i;
   assign inport1_rid_o   = outport_rid_i;
   assign inport1_rlast_o = outport_rlast_i;

endmodule
